// File: rtl/button_event_unit_pkg.sv
// rtl/button_event_unit_pkg.sv - shared button indices and per-button FSM state encodings
package button_event_unit_pkg;

    localparam int NUM_BUTTONS   = 4;

    localparam int BTN_IDX_EAST  = 3;
    localparam int BTN_IDX_WEST  = 2;
    localparam int BTN_IDX_NORTH = 1;
    localparam int BTN_IDX_SOUTH = 0;

    typedef enum logic [2:0] {
        BST_IDLE         = 3'd0,
        BST_PRESS_WAIT   = 3'd1,
        BST_HELD         = 3'd2,
        BST_REPEAT       = 3'd3,
        BST_RELEASE_WAIT = 3'd4
    } btn_state_e;

    // Every state from debounced acceptance until debounced release counts as "held".
    function automatic logic state_is_held(input btn_state_e s);
        return (s == BST_HELD) || (s == BST_REPEAT) || (s == BST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, debounce/repeat FSM, sticky pending flag
module button_channel
    import button_event_unit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_WIDTH       = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic button_i,
    input  logic ack_i,
    output logic pending_o,
    output logic held_o,
    output logic strobe_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    // Guarded so a disabled repeat never produces a negative terminal count.
    localparam logic [CNT_WIDTH-1:0] RD_LAST = CNT_WIDTH'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RP_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic                 s1_q;
    logic                 s2_q;
    btn_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 held_q, held_d;
    logic                 strobe_q;
    logic                 raise;

    // Two-flop synchroniser for the asynchronous raw button level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= button_i;
            s2_q <= s1_q;
        end
    end

    // Next state, counter and event raise for the debounce/repeat FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raise   = 1'b0;
        case (state_q)
            BST_IDLE: begin
                if (s2_q) begin
                    state_d = BST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            BST_PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = BST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = BST_HELD;
                    cnt_d   = '0;
                    raise   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BST_HELD: begin
                if (!s2_q) begin
                    state_d = BST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_DELAY != 0) begin
                    if (cnt_q == RD_LAST) begin
                        state_d = BST_REPEAT;
                        cnt_d   = '0;
                        raise   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            BST_REPEAT: begin
                if (!s2_q) begin
                    state_d = BST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == RP_LAST) begin
                    cnt_d = '0;
                    raise = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BST_RELEASE_WAIT: begin
                // A bounce back high returns to HELD and restarts the repeat delay silently.
                if (s2_q) begin
                    state_d = BST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = BST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = BST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending flag: a raise in the same cycle as an ack wins so no event is lost.
    always_comb begin
        pending_d = raise | (pending_q & ~ack_i);
        held_d    = state_is_held(state_d);
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= BST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            held_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            held_q    <= held_d;
            strobe_q  <= raise;
        end
    end

    assign pending_o = pending_q;
    assign held_o    = held_q;
    assign strobe_o  = strobe_q;

endmodule

// File: rtl/button_event_unit.sv
// rtl/button_event_unit.sv - four debounced push-button event channels for the MiniAlu core
module button_event_unit
    import button_event_unit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_WIDTH       = 25
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NUM_BUTTONS-1:0] iButton,
    input  logic [NUM_BUTTONS-1:0] iAck,
    output logic [NUM_BUTTONS-1:0] oPending,
    output logic [NUM_BUTTONS-1:0] oHeld,
    output logic [NUM_BUTTONS-1:0] oEventStrobe
);

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_east (
        .clk_i     (Clock),
        .rst_ni    (Reset),
        .button_i  (iButton[BTN_IDX_EAST]),
        .ack_i     (iAck[BTN_IDX_EAST]),
        .pending_o (oPending[BTN_IDX_EAST]),
        .held_o    (oHeld[BTN_IDX_EAST]),
        .strobe_o  (oEventStrobe[BTN_IDX_EAST])
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_west (
        .clk_i     (Clock),
        .rst_ni    (Reset),
        .button_i  (iButton[BTN_IDX_WEST]),
        .ack_i     (iAck[BTN_IDX_WEST]),
        .pending_o (oPending[BTN_IDX_WEST]),
        .held_o    (oHeld[BTN_IDX_WEST]),
        .strobe_o  (oEventStrobe[BTN_IDX_WEST])
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_north (
        .clk_i     (Clock),
        .rst_ni    (Reset),
        .button_i  (iButton[BTN_IDX_NORTH]),
        .ack_i     (iAck[BTN_IDX_NORTH]),
        .pending_o (oPending[BTN_IDX_NORTH]),
        .held_o    (oHeld[BTN_IDX_NORTH]),
        .strobe_o  (oEventStrobe[BTN_IDX_NORTH])
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_south (
        .clk_i     (Clock),
        .rst_ni    (Reset),
        .button_i  (iButton[BTN_IDX_SOUTH]),
        .ack_i     (iAck[BTN_IDX_SOUTH]),
        .pending_o (oPending[BTN_IDX_SOUTH]),
        .held_o    (oHeld[BTN_IDX_SOUTH]),
        .strobe_o  (oEventStrobe[BTN_IDX_SOUTH])
    );

endmodule

// File: tb/tb_button_event_unit.sv
// tb/tb_button_event_unit.sv - self-checking bench for button_event_unit
module tb_button_event_unit;

    localparam int A_DB = 4;
    localparam int A_RD = 0;
    localparam int A_RP = 1;
    localparam int B_DB = 2;
    localparam int B_RD = 8;
    localparam int B_RP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] ack_a, ack_b;
    logic [3:0] pend_a, held_a, stb_a;
    logic [3:0] pend_b, held_b, stb_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_event_unit #(
        .DEBOUNCE_CYCLES (A_DB),
        .REPEAT_DELAY    (A_RD),
        .REPEAT_PERIOD   (A_RP),
        .CNT_WIDTH       (4)
    ) dut_a (
        .Clock        (clk),
        .Reset        (rst_n),
        .iButton      (btn),
        .iAck         (ack_a),
        .oPending     (pend_a),
        .oHeld        (held_a),
        .oEventStrobe (stb_a)
    );

    button_event_unit #(
        .DEBOUNCE_CYCLES (B_DB),
        .REPEAT_DELAY    (B_RD),
        .REPEAT_PERIOD   (B_RP),
        .CNT_WIDTH       (4)
    ) dut_b (
        .Clock        (clk),
        .Reset        (rst_n),
        .iButton      (btn),
        .iAck         (ack_b),
        .oPending     (pend_b),
        .oHeld        (held_b),
        .oEventStrobe (stb_b)
    );

    // Reference model: the debounced level flips once DB+1 consecutive synchronised
    // samples disagree with it; repeats fire at t=RD, RD+RP, ... edges after the
    // last clean start of a hold (acceptance, or first high sample after a bounce).
    int         db_c [2] = '{A_DB, B_DB};
    int         rd_c [2] = '{A_RD, B_RD};
    int         rp_c [2] = '{A_RP, B_RP};
    logic [3:0] m_s1, m_s2;
    bit         m_lvl    [2][4];
    bit         m_glitch [2][4];
    int         m_run    [2][4];
    int         m_t      [2][4];
    logic [3:0] m_pend   [2];
    logic [3:0] m_stb    [2];

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0;
            m_stb[d]  = '0;
            for (int i = 0; i < 4; i++) begin
                m_lvl[d][i]    = 1'b0;
                m_glitch[d][i] = 1'b0;
                m_run[d][i]    = 0;
                m_t[d][i]      = 0;
            end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                bit s, raise, ack;
                s     = m_s2[i];
                raise = 1'b0;
                ack   = (d == 0) ? ack_a[i] : ack_b[i];
                if (!m_lvl[d][i]) begin
                    m_run[d][i] = s ? m_run[d][i] + 1 : 0;
                    if (m_run[d][i] == db_c[d] + 1) begin
                        m_lvl[d][i]    = 1'b1;
                        m_run[d][i]    = 0;
                        m_t[d][i]      = 0;
                        m_glitch[d][i] = 1'b0;
                        raise          = 1'b1;
                    end
                end else if (!s) begin
                    m_run[d][i]    = m_run[d][i] + 1;
                    m_glitch[d][i] = 1'b1;
                    if (m_run[d][i] == db_c[d] + 1) begin
                        m_lvl[d][i] = 1'b0;
                        m_run[d][i] = 0;
                    end
                end else begin
                    m_run[d][i] = 0;
                    if (m_glitch[d][i]) begin
                        m_glitch[d][i] = 1'b0;
                        m_t[d][i]      = 0;
                    end else begin
                        m_t[d][i] = m_t[d][i] + 1;
                        if (rd_c[d] != 0 && (m_t[d][i] == rd_c[d] ||
                            (m_t[d][i] > rd_c[d] && (m_t[d][i] - rd_c[d]) % rp_c[d] == 0)))
                            raise = 1'b1;
                    end
                end
                m_stb[d][i]  = raise;
                m_pend[d][i] = raise | (m_pend[d][i] & ~ack);
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_pending", pend_a, m_pend[0]);
        check("a_held",    held_a, {m_lvl[0][3], m_lvl[0][2], m_lvl[0][1], m_lvl[0][0]});
        check("a_strobe",  stb_a,  m_stb[0]);
        check("b_pending", pend_b, m_pend[1]);
        check("b_held",    held_b, {m_lvl[1][3], m_lvl[1][2], m_lvl[1][1], m_lvl[1][0]});
        check("b_strobe",  stb_b,  m_stb[1]);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    // dut_b acknowledges every strobe it was expected to raise on the previous cycle.
    task automatic step(input logic [3:0] b, input logic [3:0] aa);
        btn   = b;
        ack_a = aa;
        ack_b = m_stb[1];
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int nev;
        logic [3:0] rb;
        rst_n = 1'b0;
        btn   = '0;
        ack_a = '0;
        ack_b = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (10) step(4'b0000, 4'b0000);

        // Clean EAST press on dut_a: event after 7th sampled edge, no repeat.
        for (int s = 1; s <= 16; s++) begin
            step(4'b1000, 4'b0000);
            if (s == 6) check("east_early", pend_a, 4'b0000);
            if (s == 7) begin
                check("east_pend", pend_a, 4'b1000);
                check("east_stb",  stb_a,  4'b1000);
                check("east_held", held_a, 4'b1000);
            end
            if (s >= 8) check("east_no_repeat", stb_a, 4'b0000);
        end
        step(4'b0000, 4'b1000);
        repeat (12) step(4'b0000, 4'b0000);

        // WEST bursts shorter than the debounce window, then a real press.
        repeat (5) begin
            repeat (3) begin
                step(4'b0100, 4'b0000);
                check("west_glitch_held", held_a & 4'b0100, 4'b0000);
            end
            repeat (2) begin
                step(4'b0000, 4'b0000);
                check("west_glitch_held", held_a & 4'b0100, 4'b0000);
            end
        end
        nev = 0;
        repeat (10) begin
            step(4'b0100, 4'b0000);
            if (stb_a[2]) nev++;
        end
        check("west_one_event", 4'(nev), 4'd1);
        step(4'b0000, 4'b0100);
        repeat (12) step(4'b0000, 4'b0000);

        // Ack coinciding with EAST's raise: set wins; a lone ack then clears.
        for (int s = 1; s <= 7; s++)
            step(4'b1000, (s == 7) ? 4'b1000 : 4'b0000);
        check("ack_race_pend", pend_a & 4'b1000, 4'b1000);
        step(4'b1000, 4'b1000);
        check("lone_ack_clear", pend_a & 4'b1000, 4'b0000);
        repeat (14) step(4'b0000, 4'b0000);

        // NORTH auto-repeat on dut_b: accept at 5, then +8, then every 3.
        for (int s = 1; s <= 30; s++) begin
            step(4'b0010, 4'b0000);
            check("north_repeat", stb_b & 4'b0010,
                  (s == 5 || (s >= 13 && (s - 13) % 3 == 0)) ? 4'b0010 : 4'b0000);
        end
        for (int s = 1; s <= 5; s++) begin
            step(4'b0000, 4'b0000);
            check("north_release_held", held_b & 4'b0010, (s <= 4) ? 4'b0010 : 4'b0000);
        end
        repeat (10) step(4'b0000, 4'b0000);
        step(4'b0000, 4'b1111);
        step(4'b0000, 4'b0000);

        // All four together, then ack SOUTH only.
        for (int s = 1; s <= 7; s++) step(4'b1111, 4'b0000);
        check("all_pend", pend_a, 4'b1111);
        check("all_stb",  stb_a,  4'b1111);
        step(4'b1111, 4'b0001);
        check("ack_south_only", pend_a, 4'b1110);
        repeat (14) step(4'b0000, 4'b1111);

        // Reset in the middle of SOUTH's debounce, asserted between edges.
        repeat (3) step(4'b0001, 4'b0000);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("reset_async_held", held_a | held_b | stb_a | stb_b, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            step(4'b0001, 4'b0000);
            if (s == 6) check("post_reset_early", pend_a, 4'b0000);
            if (s == 7) check("post_reset_event", pend_a, 4'b0001);
        end
        repeat (14) step(4'b0000, 4'b1111);

        // Randomised traffic against the model.
        rb = '0;
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) rb[$urandom_range(0, 3)] = ~rb[$urandom_range(0, 3)];
            if ($urandom_range(0, 29) == 0) rb = 4'($urandom);
            step(rb, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_unit.md
# button_event_unit

Debounces the four Spartan-3E push-buttons, turns each debounced press into a sticky per-button event flag with optional auto-repeat, and clears the flag when the MiniAlu core acknowledges it. Sits directly upstream of the core's BEAST/BWEST/BNORTH/BSOUTH branch instructions. The core replaces its raw `BTN_*` inputs with `oPending`, and it drives `iAck` from its branch-taken-on-button decode. Every press is seen exactly once, glitch-free, even when the program polls slowly.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be ≥1.
- `REPEAT_DELAY`, 25000000: held cycles after acceptance before the first repeat event; 0 disables repeat.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat events; must be ≥1.
- `CNT_WIDTH`, 25: counter width; must hold max(all three) − 1.
- `Clock` in 1: system clock (50 MHz).
- `Reset` in 1: asynchronous, active-low reset.
- `iButton` in 4: raw, asynchronous buttons {EAST, WEST, NORTH, SOUTH}, bit 3 = EAST.
- `iAck` in 4: per-button acknowledge; a 1-cycle pulse clears the matching pending flag. Same bit order.
- `oPending` out 4: sticky event flag per button.
- `oHeld` out 4: debounced button level.
- `oEventStrobe` out 4: 1-cycle pulse in the cycle an event is raised.

## Operation
- Per button: 2-FF synchroniser (s1→s2), then a 5-state FSM with its own counter `cnt`.
- IDLE: oHeld=0. If s2=1 → PRESS_WAIT, cnt=0.
- PRESS_WAIT: if s2=0 → IDLE. Else if cnt==DEBOUNCE_CYCLES−1 → HELD, cnt=0, raise event. Else cnt++.
- HELD: oHeld=1. If s2=0 → RELEASE_WAIT, cnt=0. Else if REPEAT_DELAY≠0 and cnt==REPEAT_DELAY−1 → REPEAT, cnt=0, raise event. Else cnt++ (cnt frozen when repeat is disabled).
- REPEAT: oHeld=1. If s2=0 → RELEASE_WAIT, cnt=0. Else if cnt==REPEAT_PERIOD−1 → cnt=0, raise event. Else cnt++.
- RELEASE_WAIT: oHeld=1.
  - If s2=1 → HELD, cnt=0; the repeat delay restarts and no new event is raised.
  - Else if cnt==DEBOUNCE_CYCLES−1 → IDLE.
  - Else cnt++.
- Raise event: oEventStrobe[i]=1 for one cycle and oPending[i] is set.
- oPending[i] clears on iAck[i]=1.
  - Simultaneous raise and ack in the same cycle: set wins, so the new event is not lost.
  - Raise while already pending: the events coalesce and pending stays 1.
  - Ack while not pending: no effect.
- Buttons are fully independent; any combination may be active at once.
- Reset (asserted low, any time): all FSMs → IDLE, cnt=0, synchronisers=0, and all outputs 0. This aborts any in-progress debounce.
- A button held through reset release is treated as a fresh press and raises an event after debounce.

## Timing
- Raw level first sampled high at edge k, then stable:
  - s2=1 after edge k+1.
  - FSM enters PRESS_WAIT at edge k+2.
  - oPending/oHeld/oEventStrobe go high after edge k+2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES+1 synchronised cycles produces no event and no oHeld change.
- Release latency matches the press latency: oHeld falls after edge k+2+DEBOUNCE_CYCLES.
- First repeat comes REPEAT_DELAY cycles after the accepting edge; later repeats every REPEAT_PERIOD cycles.
- Ack pulse at edge m: oPending low after edge m, unless a raise coincides.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared definitions include file (`Defintions.v`) holds:
  - button index constants `BTN_IDX_EAST=3`, `WEST=2`, `NORTH=1`, `SOUTH=0`;
  - FSM state encodings `BST_IDLE`, `BST_PRESS_WAIT`, `BST_HELD`, `BST_REPEAT`, `BST_RELEASE_WAIT` (3 bits).
- One sub-module: `button_channel`, containing the synchroniser, FSM, counter and pending flag for one button. The top instantiates it 4× and only concatenates vectors.
- Synchroniser flops use the team's FFD_POSEDGE style, adapted to the async active-low reset.

## Test plan
- DEBOUNCE_CYCLES=4, REPEAT_DELAY=0: raise EAST clean at edge 10 → oPending=4'b1000, oHeld[3]=1 and a 1-cycle strobe after edge 16. No second event while held.
- DEBOUNCE_CYCLES=4: WEST high for 3 cycles, low 2 cycles, repeated 5 times → no event, oHeld stays 0. Then high for 10 cycles → exactly one event.
- DEBOUNCE_CYCLES=4: iAck[3] pulse at the exact edge EAST's second press raises its event → oPending[3] stays 1. A following lone ack clears it.
- DEBOUNCE_CYCLES=2, REPEAT_DELAY=8, REPEAT_PERIOD=3: hold NORTH 30 cycles, acking each strobe → strobes at acceptance +8, +11, +14, … On release, oHeld falls 4 cycles after the raw fall.
- Press all four buttons simultaneously → oPending=4'b1111 on the same cycle. Ack only SOUTH → 4'b1110.
- Assert Reset mid-PRESS_WAIT with SOUTH held → outputs 0 immediately (asynchronously). After release, the event appears DEBOUNCE_CYCLES+2 edges later.
